// File: rtl/lsu_if.sv
// Bundle of core request/response and data-memory signals for load_store_unit.
// The slave modport is the unit itself; master is the core plus memory side.
interface lsu_if;
  // Request handshake: a request transfers on the rising edge where
  // req_valid && req_ready. The core holds all req_* fields stable while
  // req_valid is high and waits for req_ready. Responses are one-cycle
  // resp_valid pulses with no backpressure.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        Memread;
  logic        Memwrite;
  logic [31:0] read_address;
  logic [31:0] write_data;
  logic [31:0] Memdata_out;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Memdata_out,
    input  req_ready, resp_valid, resp_err, resp_rdata, Memread, Memwrite, read_address, write_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, Memdata_out,
    output req_ready, resp_valid, resp_err, resp_rdata, Memread, Memwrite, read_address, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: byte/half/word access with RMW sub-word stores.
// Optional macro LSU_BOUNDS_CHECK_EN rejects word indexes >= DEPTH as errors.
module load_store_unit #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  lsu_if.slave       bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_e;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic        mem_write_q;
  logic        req_err;
  logic        oob;

  assign oob = BOUNDS_EN &&
               ((|bus.req_addr[31:IDX_W+2]) ||
                ({1'b0, bus.req_addr[IDX_W+1:2]} >= (IDX_W+1)'(DEPTH)));

  assign req_err = (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                   oob;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) m[{off, 3'b000} +: 8] = wd[7:0];
    else               m[{off[1], 4'b0000} +: 16] = wd[15:0];
    merge_lane = m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      we_q             <= 1'b0;
      size_q           <= 2'b00;
      uns_q            <= 1'b0;
      off_q            <= 2'b00;
      idx_q            <= 30'd0;
      wdata_q          <= 32'd0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_err     <= 1'b0;
      bus.resp_rdata   <= 32'd0;
      bus.Memread      <= 1'b0;
      mem_write_q      <= 1'b0;
      bus.read_address <= 32'd0;
      bus.write_data   <= 32'd0;
    end else begin
      bus.resp_valid   <= 1'b0;
      bus.resp_err     <= 1'b0;
      bus.resp_rdata   <= 32'd0;
      bus.Memread      <= 1'b0;
      mem_write_q      <= 1'b0;
      bus.read_address <= 32'd0;
      bus.write_data   <= 32'd0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            off_q         <= bus.req_addr[1:0];
            idx_q         <= bus.req_addr[31:2];
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_size == 2'b10) begin
              state            <= WRITE;
              mem_write_q      <= 1'b1;
              bus.read_address <= {2'b00, bus.req_addr[31:2]};
              bus.write_data   <= bus.req_wdata;
            end else begin
              state            <= READ;
              bus.Memread      <= 1'b1;
              bus.read_address <= {2'b00, bus.req_addr[31:2]};
            end
          end
        end
        READ: begin
          if (we_q) begin
            state            <= WRITE;
            mem_write_q      <= 1'b1;
            bus.read_address <= {2'b00, idx_q};
            bus.write_data   <= merge_lane(bus.Memdata_out, wdata_q, size_q, off_q);
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_extend(bus.Memdata_out, size_q, off_q, uns_q);
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset arriving in the WRITE cycle must suppress the write at that same edge.
  assign bus.Memwrite = mem_write_q & ~rst;
  assign state_dbg    = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard queue, reset corner case.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  lsu_if bus();

  load_store_unit #(.DEPTH(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // Simple word memory: write on rising edge, combinational read.
  logic [31:0] mem [64];
  always @(posedge clk)
    if (bus.Memwrite && bus.read_address < 32'd64) mem[bus.read_address[5:0]] <= bus.write_data;
  assign bus.Memdata_out = (bus.read_address < 32'd64) ? mem[bus.read_address[5:0]] : 32'hDEAD_BEEF;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_idx;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input logic rd, input logic wr, input logic [31:0] idx,
                              input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = err; v.exp_rdata = rdata; v.exp_lat = lat;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_idx = idx; v.exp_wdata = wd;
    return v;
  endfunction

  task automatic run_req(input vec_t v, input int id);
    int          lat;
    bit          got, rd_seen, wr_seen, both, dirty;
    logic [31:0] rd_idx, wr_data;
    logic [32:0] act, exp;
    lat = 0; got = 0; rd_seen = 0; wr_seen = 0; both = 0; dirty = 0;
    rd_idx = '0; wr_data = '0; act = '0;
    @(negedge clk);
    check($sformatf("v%0d_ready", id), 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.size;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.Memread)  begin rd_seen = 1; rd_idx = bus.read_address; end
      if (bus.Memwrite) begin wr_seen = 1; wr_data = bus.write_data; end
      if (bus.Memread && bus.Memwrite) both = 1;
      if (bus.resp_valid) begin got = 1; act = {bus.resp_err, bus.resp_rdata}; end
      else if (bus.resp_err || bus.resp_rdata != 32'd0) dirty = 1;
    end
    check($sformatf("v%0d_resp_seen", id), 64'(got), 64'd1);
    exp = exp_q.pop_front();
    if (got) begin
      check($sformatf("v%0d_resp", id), 64'(act), 64'(exp));
      check($sformatf("v%0d_latency", id), 64'(lat), 64'(v.exp_lat));
    end
    check($sformatf("v%0d_memread", id), 64'(rd_seen), 64'(v.exp_rd));
    check($sformatf("v%0d_memwrite", id), 64'(wr_seen), 64'(v.exp_wr));
    check($sformatf("v%0d_rd_wr_overlap", id), 64'(both), 64'd0);
    check($sformatf("v%0d_idle_resp_zero", id), 64'(dirty), 64'd0);
    if (rd_seen && v.exp_rd) check($sformatf("v%0d_read_address", id), 64'(rd_idx), 64'(v.exp_idx));
    if (wr_seen && v.exp_wr) check($sformatf("v%0d_write_data", id), 64'(wr_data), 64'(v.exp_wdata));
  endtask

  initial begin
    logic [31:0] rdata;
    bit          saw_resp, saw_wr;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[2] = 32'h0000_0005;
    mem[3] = 32'h80FF_7F01;
    mem[4] = 32'h1122_3344;
    mem[8] = 32'h1234_5678;

    // Vector table: we, size, uns, addr, wdata, err, rdata, lat, rd, wr, idx, write_data
    vecs.push_back(mk(0, 2'b10, 0, 32'h08, 0, 0, 32'h0000_0005, 2, 1, 0, 2, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0E, 0, 0, 32'hFFFF_FFFF, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0E, 0, 0, 32'h0000_00FF, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0E, 0, 0, 32'hFFFF_80FF, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0C, 0, 0, 32'h0000_7F01, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0D, 0, 0, 32'h0000_007F, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0F, 0, 0, 32'hFFFF_FF80, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0F, 0, 0, 32'h0000_0080, 2, 1, 0, 3, 0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0C, 0, 0, 32'h0000_7F01, 2, 1, 0, 3, 0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h11, 32'h0000_00AB, 0, 0, 3, 1, 1, 4, 32'h1122_AB44));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 0, 0, 32'h1122_AB44, 2, 1, 0, 4, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h13, 32'h0000_BEEF, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h06, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h00, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h12, 32'h5555_5555, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h12, 32'h1234_BEEF, 0, 0, 3, 1, 1, 4, 32'hBEEF_AB44));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 0, 0, 32'hBEEF_AB44, 2, 1, 0, 4, 0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h14, 32'hCAFE_F00D, 0, 0, 2, 0, 1, 5, 32'hCAFE_F00D));
    vecs.push_back(mk(0, 2'b10, 0, 32'h14, 0, 0, 32'hCAFE_F00D, 2, 1, 0, 5, 0));
`ifdef LSU_BOUNDS_CHECK_EN
    vecs.push_back(mk(0, 2'b10, 0, 32'h100, 0, 1, 0, 1, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, 2'b10, 0, 32'h100, 0, 0, 32'hDEAD_BEEF, 2, 1, 0, 64, 0));
`endif
    for (int i = 0; i < 6; i++) begin
      logic [31:0] idx, data;
      idx  = 32'($urandom_range(16, 63));
      data = $urandom;
      vecs.push_back(mk(1, 2'b10, 0, idx << 2, data, 0, 0, 2, 0, 1, idx, data));
      vecs.push_back(mk(0, 2'b10, 0, idx << 2, 0, 0, data, 2, 1, 0, idx, 0));
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_memread", 64'(bus.Memread), 64'd0);
    check("rst_memwrite", 64'(bus.Memwrite), 64'd0);
    check("rst_read_address", 64'(bus.read_address), 64'd0);
    check("rst_write_data", 64'(bus.write_data), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_req(vecs[i], i);

    // Reset asserted during the WRITE cycle of a word store to word 8
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_memwrite", 64'(bus.Memwrite), 64'd0);
    check("abort_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b0;
    saw_resp = 0; saw_wr = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) saw_resp = 1;
      if (bus.Memwrite) saw_wr = 1;
    end
    check("abort_no_resp", 64'(saw_resp), 64'd0);
    check("abort_no_later_write", 64'(saw_wr), 64'd0);
    check("abort_word8_kept", 64'(mem[8]), 64'h1234_5678);

    // Unit is usable again after the aborted request
    run_req(mk(0, 2'b10, 0, 32'h20, 0, 0, 32'h1234_5678, 2, 1, 0, 8, 0), 100);

    rdata = mem[4];
    check("final_mem4", 64'(rdata), 64'hBEEF_AB44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side memory access controller between the core's execute stage and the word-indexed data memory. It accepts one load/store request at a time through a valid/ready handshake. It performs byte/halfword/word accesses with little-endian lane selection and sign/zero extension, using read-modify-write for sub-word stores. It returns a single-cycle response with read data or an error flag.

Parameters:
DEPTH, 64, number of 32-bit words in the attached data memory (used by the bounds check)
IDX_W, 6, width of the word index actually significant in DEPTH (log2 DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  unit can accept a request; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_err  output  1  qualifies resp_valid: misaligned, reserved size or out-of-range access
resp_rdata  output  32  extended load data; 0 for stores and errors
Memread  output  1  memory read enable
Memwrite  output  1  memory write enable, sampled by memory on rising edge
read_address  output  32  word index = {2'b00, addr[31:2]}
write_data  output  32  full word to write
Memdata_out  input  32  combinational read data from memory, valid in the same cycle as Memread

Behaviour:
- Handshake: the request is accepted on a rising edge with req_valid && req_ready. All request fields are latched into internal registers at that edge. No response backpressure: resp_valid is high for exactly one cycle, then the unit returns to IDLE.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1, all memory outputs 0. On accept, check for errors:
  - size=11 is an error.
  - halfword with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - On error: go to RESP with err latched; no memory access ever issued.
  - Otherwise:
    - load -> READ
    - word store -> WRITE
    - byte/half store -> READ
- READ: Memread=1, read_address=latched index. Memdata_out is captured into the word register at the rising edge. Next state: RESP for loads, WRITE for stores.
- WRITE: Memwrite=1 for exactly one cycle.
  - Word store: write_data = wdata.
  - Sub-word store: captured word with the selected lane replaced. Byte lane = addr[1:0] (bits 8*off+7:8*off). Half lane = addr[1] (bits 16*h+15:16*h).
  - Next state: RESP.
- RESP: resp_valid=1, resp_err from the latched flag.
  - Loads: resp_rdata = selected lane of the captured word, extended to 32 bits per req_unsigned; word loads pass through.
  - Next state: IDLE. A new request can be accepted in the following cycle.
- Latency from accept edge to resp_valid:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Memread, Memwrite, read_address and write_data are decoded from registered state and latched fields only, with no combinational path from req_*. Memread and Memwrite are never high together. Outside READ/WRITE, read_address=0 and write_data=0.
- Reset: state=IDLE, all latched fields 0. Outputs after reset: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, Memread=0, Memwrite=0, read_address=0, write_data=0. Reset asserted during READ/WRITE aborts the operation, and no write occurs at or after the reset edge. An aborted request gets no response.
- Between responses, resp_rdata and resp_err hold 0.

Optional Feature:
LSU_BOUNDS_CHECK_EN:
- Defined: in IDLE, a word index addr[31:2] >= DEPTH is an error, handled identically to misalignment (RESP with resp_err=1, no memory access).
- Undefined: no range check; the full index is driven on read_address and range behaviour is the memory's concern.

Test Plan:
- Memory word 2 = 0x0000_0005; load word addr 0x8 -> Memread high 1 cycle with read_address=2; resp_valid 2 cycles after accept; resp_rdata=0x0000_0005, resp_err=0.
- Word 3 = 0x80FF_7F01:
  - signed byte load addr 0xE -> 0xFFFF_FFFF
  - unsigned byte load addr 0xE -> 0x0000_00FF
  - signed half load addr 0xE -> 0xFFFF_80FF
  - unsigned half load addr 0xC -> 0x0000_7F01
- Word 4 = 0x1122_3344; byte store 0xAB to addr 0x11 -> READ then WRITE with write_data=0x1122_AB44; resp at 3 cycles. Then a word load of addr 0x10 returns 0x1122_AB44.
- Half store addr 0x13 and word load addr 0x6 -> resp_valid with resp_err=1 one cycle after accept; Memread and Memwrite stay 0 throughout.
- Reset asserted in the WRITE cycle of a word store to addr 0x20 -> Memwrite is 0 after the reset edge, no resp_valid, req_ready=1, word 8 unchanged.
- With LSU_BOUNDS_CHECK_EN and DEPTH=64, load addr 0x100 -> resp_err=1 and no Memread. Without the macro, Memread is issued with read_address=64.
